// File: rtl/fifo_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_arb_pkg
//  Description : Shared definitions for the shared-RAM FIFO read engine:
//                channel count, select/word widths, output-queue geometry,
//                FSM state encoding, stage/queue entry structs and the
//                round-robin index helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_rd_arb_pkg;

    localparam int c_num_ch   = 8;   // channels sharing the FIFO RAM
    localparam int c_sel_w    = 3;   // channel select width
    localparam int c_dat_w    = 36;  // RAM word width
    localparam int c_oq_depth = 4;   // output queue entries
    localparam int c_oq_ptr_w = 2;   // output queue pointer width
    localparam int c_oq_cnt_w = 3;   // output queue occupancy width (0..4)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    // Capture stage holding the most recent RAM word.
    typedef struct packed {
        logic               v;
        logic [c_dat_w-1:0] dat;
        logic [c_sel_w-1:0] ch;
    } stage_t;

    // Output queue entry.
    typedef struct packed {
        logic [c_dat_w-1:0] dat;
        logic [c_sel_w-1:0] ch;
        logic               last;
    } oq_entry_t;

    // Channel index 'offset' positions above 'base', wrapping modulo 8.
    function automatic logic [c_sel_w-1:0] rr_index(input logic [c_sel_w-1:0] base,
                                                    input int                 offset);
        return base + c_sel_w'(offset);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_arb
//  Description : 8-way round-robin arbiter. The grant is combinational from
//                the request vector and the registered last-grant pointer;
//                the pointer moves to the granted channel on i_upd.
//  Ports       : clk, rst (async, active high)
//                i_req[7:0]  request vector
//                i_upd       accept current grant and advance pointer
//                o_gnt_vld   some channel is requesting
//                o_gnt_idx   granted channel
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rr_arb
    import fifo_rd_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [c_num_ch-1:0] i_req,
    input  logic                i_upd,
    output logic                o_gnt_vld,
    output logic [c_sel_w-1:0]  o_gnt_idx
);

    logic [c_sel_w-1:0] r_last_gnt_q;
    logic [c_sel_w-1:0] w_last_gnt_d;
    logic [c_sel_w-1:0] w_idx;

    // Scan from the farthest offset down to the nearest so that the channel
    // closest above the pointer is the one left standing.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = r_last_gnt_q;
        w_idx     = r_last_gnt_q;
        for (int i = c_num_ch; i >= 1; i--) begin
            w_idx = rr_index(r_last_gnt_q, i);
            if (i_req[w_idx]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_last_gnt_d = r_last_gnt_q;
        if (i_upd && o_gnt_vld) begin
            w_last_gnt_d = o_gnt_idx;
        end
    end

    // Pointer resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt_q <= c_sel_w'(c_num_ch - 1);
        end else begin
            r_last_gnt_q <= w_last_gnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_arb
//  Description : Read-side engine of the 8-channel shared-RAM async FIFO.
//                Round-robin arbitrates over enabled non-empty channels,
//                drains up to BURST_LEN words per grant, captures the RAM's
//                registered data and presents tagged words on a valid/ready
//                stream through a 4-entry first-word-fall-through queue.
//  Ports       : clk, rst (async, active high)
//                b_fifo_empty_i[7:0], b_re_o, b_fifo_sel_o[2:0], b_dat_i[35:0]
//                ch_en_i[7:0]
//                dat_o[35:0], ch_o[2:0], last_o, vld_o, rdy_i, busy_o
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_arb
    import fifo_rd_arb_pkg::*;
#(
    parameter int BURST_LEN = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [c_num_ch-1:0] b_fifo_empty_i,
    output logic                b_re_o,
    output logic [c_sel_w-1:0]  b_fifo_sel_o,
    input  logic [c_dat_w-1:0]  b_dat_i,
    input  logic [c_num_ch-1:0] ch_en_i,
    output logic [c_dat_w-1:0]  dat_o,
    output logic [c_sel_w-1:0]  ch_o,
    output logic                last_o,
    output logic                vld_o,
    input  logic                rdy_i,
    output logic                busy_o
);

    localparam int                c_cnt_w     = $clog2(BURST_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(BURST_LEN);

    rd_state_e              r_state_q,    w_state_d;
    logic [c_sel_w-1:0]     r_sel_q,      w_sel_d;
    logic [c_cnt_w-1:0]     r_cnt_q,      w_cnt_d;
    logic                   r_inflight_q, w_inflight_d;
    stage_t                 r_stage_q,    w_stage_d;

    oq_entry_t              r_oq_q [c_oq_depth];
    oq_entry_t              w_oq_d [c_oq_depth];
    logic [c_oq_ptr_w-1:0]  r_oq_wr_q,  w_oq_wr_d;
    logic [c_oq_ptr_w-1:0]  r_oq_rd_q,  w_oq_rd_d;
    logic [c_oq_cnt_w-1:0]  r_oq_cnt_q, w_oq_cnt_d;

    logic                   w_req_vld;
    logic [c_sel_w-1:0]     w_req_idx;
    logic                   w_arb_upd;
    logic                   w_re;
    logic                   w_sel_empty;
    logic                   w_budget_ok;
    logic                   w_push;
    oq_entry_t              w_push_ent;
    logic                   w_pop;

    fifo_rr_arb u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (ch_en_i & ~b_fifo_empty_i),
        .i_upd     (w_arb_upd),
        .o_gnt_vld (w_req_vld),
        .o_gnt_idx (w_req_idx)
    );

    // ------------------------------------------------------------------
    // Control FSM and capture stage
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_sel_d     = r_sel_q;
        w_cnt_d     = r_cnt_q;
        w_stage_d   = r_stage_q;
        w_arb_upd   = 1'b0;
        w_re        = 1'b0;
        w_push      = 1'b0;
        w_push_ent  = '0;
        w_sel_empty = b_fifo_empty_i[r_sel_q];
        // Everything already held (queue plus stage) must leave room for the
        // word about to be read, which lands in the stage and may push the
        // stage's previous word into the queue.
        w_budget_ok = (r_oq_cnt_q + c_oq_cnt_w'(r_stage_q.v)) <= c_oq_cnt_w'(c_oq_depth - 1);

        // RAM data is valid the cycle after a read; retire any older word.
        if (r_inflight_q) begin
            w_stage_d.v   = 1'b1;
            w_stage_d.dat = b_dat_i;
            w_stage_d.ch  = r_sel_q;
            if (r_stage_q.v) begin
                w_push          = 1'b1;
                w_push_ent.dat  = r_stage_q.dat;
                w_push_ent.ch   = r_stage_q.ch;
                w_push_ent.last = 1'b0;
            end
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_req_vld) begin
                    w_sel_d   = w_req_idx;
                    w_cnt_d   = '0;
                    w_arb_upd = 1'b1;
                    w_state_d = ST_READ;
                end
            end
            ST_READ: begin
                // The empty flag lags a read by one cycle, so decisions are
                // only taken with no read in flight.
                if (!r_inflight_q) begin
                    if (!w_sel_empty && (r_cnt_q < c_burst_max) && w_budget_ok) begin
                        w_re    = 1'b1;
                        w_cnt_d = r_cnt_q + 1'b1;
                    end else if ((r_cnt_q == c_burst_max) || w_sel_empty) begin
                        w_state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // The stage always holds the burst's final word here.
                w_push          = 1'b1;
                w_push_ent.dat  = r_stage_q.dat;
                w_push_ent.ch   = r_stage_q.ch;
                w_push_ent.last = 1'b1;
                w_stage_d       = '0;
                w_state_d       = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_inflight_d = w_re;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_sel_q      <= '0;
            r_cnt_q      <= '0;
            r_inflight_q <= 1'b0;
            r_stage_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_sel_q      <= w_sel_d;
            r_cnt_q      <= w_cnt_d;
            r_inflight_q <= w_inflight_d;
            r_stage_q    <= w_stage_d;
        end
    end

    // ------------------------------------------------------------------
    // Output queue (first-word-fall-through)
    // ------------------------------------------------------------------
    assign w_pop = vld_o & rdy_i;

    always_comb begin
        for (int i = 0; i < c_oq_depth; i++) begin
            w_oq_d[i] = r_oq_q[i];
        end
        if (w_push) begin
            w_oq_d[r_oq_wr_q] = w_push_ent;
        end
        w_oq_wr_d  = r_oq_wr_q + c_oq_ptr_w'(w_push);
        w_oq_rd_d  = r_oq_rd_q + c_oq_ptr_w'(w_pop);
        w_oq_cnt_d = r_oq_cnt_q + c_oq_cnt_w'(w_push) - c_oq_cnt_w'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_oq_depth; i++) begin
                r_oq_q[i] <= '0;
            end
            r_oq_wr_q  <= '0;
            r_oq_rd_q  <= '0;
            r_oq_cnt_q <= '0;
        end else begin
            for (int i = 0; i < c_oq_depth; i++) begin
                r_oq_q[i] <= w_oq_d[i];
            end
            r_oq_wr_q  <= w_oq_wr_d;
            r_oq_rd_q  <= w_oq_rd_d;
            r_oq_cnt_q <= w_oq_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; payload is zeroed whenever nothing is valid.
    // ------------------------------------------------------------------
    assign vld_o        = (r_oq_cnt_q != '0);
    assign dat_o        = vld_o ? r_oq_q[r_oq_rd_q].dat  : '0;
    assign ch_o         = vld_o ? r_oq_q[r_oq_rd_q].ch   : '0;
    assign last_o       = vld_o ? r_oq_q[r_oq_rd_q].last : 1'b0;
    assign b_re_o       = w_re;
    assign b_fifo_sel_o = r_sel_q;
    assign busy_o       = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire
